// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, registered mispredict
// flush/redirect and saturating performance counters.
module branch_predictor #(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [31:0]     pred_target,
   input  logic            resolve_valid,
   input  logic [PC_W-1:0] resolve_pc,
   input  logic            resolve_taken,
   input  logic            resolve_uncond,
   input  logic [31:0]     resolve_target,
   input  logic            resolve_pred_taken,
   input  logic [31:0]     resolve_pred_target,
   output logic            flush,
   output logic [31:0]     redirect_pc,
   output logic [15:0]     mispredict_cnt,
   output logic [15:0]     resolve_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   if (TAG_W < 1 || ENTRIES < 2 || ENTRIES > 256 ||
       (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_cfg
      $error("branch_predictor: bad ENTRIES/PC_W combination");
   end

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [1:0]       ctr;
   } btb_entry_t;

   btb_entry_t btb [ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   btb_entry_t       f_ent;
   logic             f_hit;
   logic [PC_W-1:0]  f_seq;

   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   btb_entry_t       r_ent;
   btb_entry_t       r_nxt;
   logic             r_hit;
   logic             r_wr;
   logic [PC_W-1:0]  r_seq;
   logic [PC_W-1:0]  r_tgt;
   logic             mispredict;
   logic [PC_W-1:0]  redir_nxt;
   logic             unused_bits;

   // Upper target bits are carried for the pipeline but never stored.
   assign unused_bits = ^{resolve_target, resolve_pred_target};

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
   assign f_ent = btb[f_idx];
   assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
   assign f_seq = fetch_pc + PC_W'(4);

   assign pred_taken  = f_hit && f_ent.ctr[1];
   assign pred_target = pred_taken ? 32'(f_ent.target) : 32'(f_seq);

   assign r_idx = resolve_pc[IDX_W+1:2];
   assign r_tag = resolve_pc[PC_W-1:IDX_W+2];
   assign r_ent = btb[r_idx];
   assign r_hit = r_ent.valid && (r_ent.tag == r_tag);
   assign r_seq = resolve_pc + PC_W'(4);
   assign r_tgt = resolve_target[PC_W-1:0];

   assign mispredict = resolve_valid &&
      ((resolve_taken != resolve_pred_taken) ||
       (resolve_taken &&
        (r_tgt != resolve_pred_target[PC_W-1:0])));

   assign redir_nxt = resolve_taken ? r_tgt : r_seq;

   always_comb begin
      r_nxt = r_ent;
      r_wr  = 1'b0;
      if (resolve_valid) begin
         if (r_hit) begin
            r_wr = 1'b1;
            if (resolve_uncond) begin
               r_nxt.ctr = 2'd3;
            end else if (resolve_taken) begin
               if (r_ent.ctr != 2'd3) r_nxt.ctr = r_ent.ctr + 2'd1;
            end else begin
               if (r_ent.ctr != 2'd0) r_nxt.ctr = r_ent.ctr - 2'd1;
            end
            if (resolve_taken) r_nxt.target = r_tgt;
         end else if (resolve_taken) begin
            r_wr         = 1'b1;
            r_nxt.valid  = 1'b1;
            r_nxt.tag    = r_tag;
            r_nxt.target = r_tgt;
            r_nxt.ctr    = resolve_uncond ? 2'd3 : 2'd2;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'd1};
         end
      end else if (r_wr) begin
         btb[r_idx] <= r_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush          <= 1'b0;
         redirect_pc    <= '0;
         mispredict_cnt <= '0;
         resolve_cnt    <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict) redirect_pc <= 32'(redir_nxt);
         if (resolve_valid && resolve_cnt != 16'hFFFF)
            resolve_cnt <= resolve_cnt + 16'd1;
         if (mispredict && mispredict_cnt != 16'hFFFF)
            mispredict_cnt <= mispredict_cnt + 16'd1;
      end
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 9, SHALL set the program-counter width in bits.
REQ-002 Parameter ENTRIES, default 16, SHALL set the BTB entry count; it SHALL be a power of two, 2..256.
REQ-003 Derived IDX_W = log2(ENTRIES); TAG_W = PC_W-IDX_W-2; a configuration with TAG_W<1 SHALL be rejected at elaboration.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fetch_pc  in  PC_W  PC being fetched this cycle.
REQ-007 pred_taken  out  1  combinational prediction for fetch_pc.
REQ-008 pred_target  out  32  combinational predicted next PC, zero-extended from PC_W.
REQ-009 resolve_valid  in  1  a control-flow instruction resolves this cycle.
REQ-010 resolve_pc  in  PC_W  PC of the resolving instruction.
REQ-011 resolve_taken  in  1  actual outcome (conditional branch result, or 1 for jal/jalr).
REQ-012 resolve_uncond  in  1  resolving instruction is jal or jalr.
REQ-013 resolve_target  in  32  actual taken target (PC+Imm, or reg+imm for jalr); only bits [PC_W-1:0] are used.
REQ-014 resolve_pred_taken, resolve_pred_target  in  1, 32  the prediction made at fetch, carried down the pipeline.
REQ-015 flush  out  1  registered one-cycle mispredict pulse.
REQ-016 redirect_pc  out  32  registered correct next PC, valid while flush=1.
REQ-017 mispredict_cnt, resolve_cnt  out  16 each  performance counters.

Function
REQ-018 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; each entry holds valid, tag, target[PC_W-1:0], and a 2-bit saturating counter ctr.
REQ-019 Lookup hit SHALL be valid && tag match; pred_taken = hit && ctr[1]; pred_target = target when pred_taken, else fetch_pc+4 truncated to PC_W (wraps modulo 2^PC_W).
REQ-020 When resolve_valid=1 and the entry hits on resolve_pc: conditional -> ctr increments on taken, decrements on not-taken, saturating at 0 and 3; unconditional -> ctr set to 3; target is overwritten with resolve_target only when resolve_taken=1.
REQ-021 When resolve_valid=1, the entry misses, and resolve_taken=1: the entry is allocated (valid=1, new tag, target=resolve_target, ctr=3 if resolve_uncond, else 2), replacing any prior occupant.
REQ-022 A miss with resolve_taken=0 SHALL NOT allocate or modify any entry.
REQ-023 Mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target[PC_W-1:0] != resolve_pred_target[PC_W-1:0])).
REQ-024 On the edge after a mispredict, flush SHALL be 1 for exactly one cycle, with redirect_pc = resolve_taken ? resolve_target[PC_W-1:0] : resolve_pc+4 (PC_W wrap), zero-extended; otherwise flush=0 and redirect_pc holds its last value.
REQ-025 Back-to-back mispredicts SHALL produce flush on consecutive cycles, each carrying its own redirect_pc.
REQ-026 Same-cycle lookup and update of the same entry: lookup SHALL return the pre-update contents; the update is visible from the next cycle.
REQ-027 resolve_cnt SHALL increment on each resolve_valid; mispredict_cnt SHALL increment on each mispredict; both saturate at 16'hFFFF.
REQ-028 All inputs other than fetch_pc SHALL be ignored when resolve_valid=0.

Reset
REQ-029 While reset=1, asynchronously: all valid=0, all ctr=1, all tags and targets=0, flush=0, redirect_pc=0, both counters=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending flush; the first edge after deassertion SHALL behave as a cold start.

Verification
REQ-031 After reset, fetch_pc=0x40 -> pred_taken=0, pred_target=0x44; resolve pc=0x40, taken=1, target=0x80, pred_taken=0 -> next cycle flush=1, redirect_pc=0x80, then fetch 0x40 -> pred_taken=1, pred_target=0x80.
REQ-032 Conditional branch at 0x10 resolved T,T,N,N,N -> ctr 2,3,2,1,0; pred_taken 1,1,1,0,0 after each update; mispredict_cnt incremented at each flip.
REQ-033 Aliasing: resolve taken at 0x04 then at 0x44 (ENTRIES=16, same index, different tag) -> 0x04 misses afterwards, 0x44 hits.
REQ-034 jalr at 0x20 with predicted target 0x60, actual 0x70 -> flush=1, redirect_pc=0x70, ctr=3, stored target=0x70.
REQ-035 fetch_pc=0x1FC with PC_W=9 and no hit -> pred_target=0x000; reset asserted while flush pending -> flush=0 immediately and counters=0.
